// File: rtl/mak_bus_pkg.sv
// Shared definitions for the memory-mapped responder.
//   state_t          : responder FSM state encoding (also visible on the debug port)
//   ERR_DATA_DEFAULT : read data returned for a missed or misaligned access
//   PAGE_LSB/IDX_*   : address field positions used by the window decoder
//   decode_hit()     : window / alignment / depth check for a byte address
package mak_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Byte address layout: [31:12] page, [11:2] word index, [1:0] byte offset.
    localparam int PAGE_LSB = 12;
    localparam int IDX_LSB  = 2;
    localparam int IDX_W    = 10;
    localparam int WAIT_W   = 4;

    function automatic logic decode_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [IDX_W-1:0] idx;
        idx = addr[IDX_LSB +: IDX_W];
        return (addr[31:PAGE_LSB] == base[31:PAGE_LSB]) &&
               (addr[1:0] == 2'b00) &&
               ({{(32-IDX_W){1'b0}}, idx} < depth);
    endfunction

endpackage

// File: rtl/responder_sram.sv
// Single-port synchronous word store for mem_responder.
//   clk   : clock
//   en    : access strobe for this cycle
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data; only a read updates it, so a write leaves
//           the last read value in place (no-change mode of a block RAM)
module responder_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped word responder with programmable wait states.
//   clk, rst           : clock, synchronous active-high reset
//   mem_req            : transfer request (level), sampled only in IDLE
//   mem_we             : 1 = write, 0 = read
//   mem_addr/mem_wdata : byte address and write data, captured at accept
//   cfg_wait           : wait states, captured at accept
//   mem_rdata          : registered read data, held until the next read completes
//   mem_ready          : one-cycle completion pulse
//   err_flag/err_clr   : sticky miss/misalignment flag and its clear (set wins)
//   rd_count/wr_count  : saturating counts of completed hit reads / writes
//   fsm_state          : current FSM state, for observation only
//
// Handshake: a transfer is accepted on a clock edge where the FSM is IDLE and
// mem_req=1. mem_ready rises cfg_wait+1 edges later and stays high for one
// cycle. The RESP->IDLE edge that raises mem_ready never accepts; the edge
// closing the mem_ready cycle may accept a new request, so a held mem_req
// yields one completion every two cycles when cfg_wait=0. Once accepted a
// transfer always completes unless rst is asserted.
module mem_responder
    import mak_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic              err_flag,
    input  logic              err_clr,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output state_t            fsm_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              accept;

    logic [31:0]       addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;

    logic              ready_q;
    logic              err_q;
    logic [15:0]       rd_cnt_q;
    logic [15:0]       wr_cnt_q;

    // mem_rdata is either the SRAM's registered output (after a hit read) or
    // a local register holding reset zero / ERR_DATA (after a missed read).
    logic              use_sram_q;
    logic [31:0]       rdata_reg_q;
    logic [31:0]       sram_rdata;

    logic              resp;
    logic              hit;
    logic              sram_en;

    assign resp = (state_q == ST_RESP);
    assign hit  = decode_hit(addr_q, BASE_ADDR, DEPTH_WORDS);
    // Gating with rst keeps a reset on the RESP edge from committing a write.
    assign sram_en = resp && hit && !rst;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    accept  = 1'b1;
                    wait_d  = cfg_wait;
                    state_d = (cfg_wait != '0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                // Leaving on the count of 1 gives cfg_wait cycles spent in
                // IDLE->WAIT plus WAIT, then RESP, then the mem_ready cycle.
                wait_d = wait_q - 1'b1;
                if (wait_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            use_sram_q  <= 1'b0;
            rdata_reg_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ready_q <= resp;

            if (accept) begin
                addr_q  <= mem_addr;
                we_q    <= mem_we;
                wdata_q <= mem_wdata;
            end

            if (resp && !we_q) begin
                if (hit) begin
                    use_sram_q <= 1'b1;
                end else begin
                    use_sram_q  <= 1'b0;
                    rdata_reg_q <= ERR_DATA;
                end
            end

            if (resp && !hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            if (resp && hit && !we_q && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (resp && hit && we_q && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    responder_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (we_q),
        .addr  (addr_q[IDX_LSB +: AW]),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    assign mem_rdata = use_sram_q ? sram_rdata : rdata_reg_q;
    assign mem_ready = ready_q;
    assign err_flag  = err_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- BASE_ADDR, 32'h2000_0000, window base; only bits [31:12] are decoded.
- DEPTH_WORDS, 1024, word storage depth.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

REQ-002 SHALL have these ports: one clock; reset is synchronous and active-high.
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- mem_req, in, 1, transfer request (level).
- mem_we, in, 1, 1=write, 0=read.
- mem_addr, in, 32, byte address.
- mem_wdata, in, 32, write data.
- mem_rdata, out, 32, read data.
- mem_ready, out, 1, single-cycle completion pulse.
- cfg_wait, in, 4, wait states, sampled at accept.
- err_flag, out, 1, sticky error indication.
- err_clr, in, 1, clears err_flag.
- rd_count, out, 16, completed reads (saturating).
- wr_count, out, 16, completed writes (saturating).

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-004 In IDLE with mem_req=1, SHALL accept: capture addr/we/wdata, load wait counter with cfg_wait, go to WAIT when cfg_wait!=0, else RESP.
REQ-005 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-006 In RESP, SHALL perform the array access; the next cycle SHALL assert mem_ready=1 for exactly one cycle and return to IDLE.
- Latency from the accept edge to mem_ready high = cfg_wait+1 cycles.
- Therefore cfg_wait=0 gives mem_ready in the cycle after the accept edge.
REQ-007 SHALL NOT sample request inputs while mem_ready=1; the earliest next accept is the cycle after the mem_ready pulse (supports req held high across back-to-back read->write).
REQ-008 mem_rdata SHALL be registered, valid during the mem_ready cycle, and held until the next completion; writes leave mem_rdata unchanged.
REQ-009 A decode hit SHALL require mem_addr[31:12]==BASE_ADDR[31:12], mem_addr[1:0]==0, and word index addr[11:2] < DEPTH_WORDS.
REQ-010 On a hit, a read SHALL return array[addr[11:2]], and a write SHALL update that word on the RESP edge.
REQ-011 On a miss or misalignment, SHALL still complete the handshake with normal latency.
- Read returns ERR_DATA.
- Write is dropped.
- err_flag set to 1 in the mem_ready cycle.
REQ-012 err_flag SHALL be sticky until err_clr=1; if a set and err_clr coincide, set wins.
REQ-013 rd_count/wr_count SHALL increment on each mem_ready of a hit read/write, saturate at 16'hFFFF, and not count errored transfers.
REQ-014 mem_req dropping while in WAIT/RESP SHALL NOT abort the transfer; it completes and pulses mem_ready.
REQ-015 cfg_wait changes during a transfer SHALL NOT affect the transfer in flight.

Reset
REQ-016 With rst=1 at a clk edge, SHALL set:
- state=IDLE, mem_ready=0, mem_rdata=0, err_flag=0, rd_count=0, wr_count=0, wait counter=0.
REQ-017 Reset mid-transfer SHALL abandon the transfer (no mem_ready, no write commit); array contents are not cleared.
REQ-018 The first accept after reset SHALL be possible in the first cycle with rst=0.

Structure
REQ-019 State enum, ERR_DATA default and the address-decode field widths SHALL live in shared package mak_bus_pkg.
REQ-020 Storage SHALL be a sub-module responder_sram: single-port, synchronous read/write, DEPTH_WORDS x 32, inferable as BRAM.
REQ-021 Decode, FSM, counters and error logic SHALL reside in mem_responder.

Verification
REQ-022 Read with cfg_wait=0: preload word 5=32'h1234_5678; read addr 32'h2000_0014 -> mem_ready one cycle after accept, mem_rdata=32'h1234_5678, rd_count=1.
REQ-023 Back-to-back transfers with mem_req held high: read 32'h2000_0000 then write 32'h2000_0100 data 32'hA5A5_A5A5 -> two mem_ready pulses 2 cycles apart, then read-back returns 32'hA5A5_A5A5, wr_count=1.
REQ-024 Wait states: cfg_wait=3, read -> mem_ready exactly 4 cycles after the accept edge; change cfg_wait to 0 mid-transfer -> latency still 4.
REQ-025 Error paths:
- Read 32'h3000_0000 -> mem_rdata=32'hDEAD_BEEF, err_flag=1, rd_count unchanged.
- Write 32'h2000_0002 -> dropped, err_flag stays 1 until err_clr.
REQ-026 Reset mid-write with cfg_wait=5: assert rst 2 cycles after accept -> no mem_ready, target word unchanged, all outputs at reset values.
REQ-027 Saturation: force 65537 hit reads -> rd_count=16'hFFFF.
